bcd_digit_entry: RTL and testbench

//  Upstream feeder for the BCD-to-binary converter. Collects decimal digits one at a time

---
 rtl/bcd_digit_entry.sv | 123 ++++++++++++
 tb/tb_bcd_digit_entry.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_entry.sv
// ============================================================================
//  Module      : bcd_digit_entry
//  Description : Collects decimal digits over a valid/ready handshake and packs
//                them MSD-first into an NDIGITS-digit packed BCD word. A commit
//                (ENTER, or a full entry when AUTO_COMMIT_EN is defined)
//                publishes the word on bcd with a one-cycle bcd_valid strobe.
//  Macro       : AUTO_COMMIT_EN - when defined, the digit that fills the
//                working register commits it immediately (FULL never held).
//  Ports       :
//    clk        in   1          rising-edge clock
//    rst_n      in   1          asynchronous active-low reset
//    dig_valid  in   1          source offers a digit this cycle
//    dig        in   4          digit value, legal 0..9
//    dig_ready  out  1          block can accept a digit this cycle
//    enter      in   1          commit request, level sampled each cycle
//    clear      in   1          synchronous discard of partial entry and err
//    bcd        out  4*NDIGITS  last committed packed BCD word, MSD on top
//    bcd_valid  out  1          one-cycle strobe, bcd updated this cycle
//    err        out  1          sticky: an illegal digit (>9) was offered
//    cnt        out  CW         digits currently held in working register
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_entry #(
   parameter  int NDIGITS = 2,
   localparam int W       = 4 * NDIGITS,
   localparam int CW      = $clog2(NDIGITS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          dig_valid,
   input  logic [3:0]    dig,
   output logic          dig_ready,
   input  logic          enter,
   input  logic          clear,
   output logic [W-1:0]  bcd,
   output logic          bcd_valid,
   output logic          err,
   output logic [CW-1:0] cnt
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  work;

   logic          accept;
   logic          legal;
   logic          take;
   logic [W-1:0]  work_nx;
   logic [CW-1:0] cnt_nx;
   logic          full_nx;
   logic          commit;

   // Ready depends only on state and clear so the source never sees a
   // combinational path from its own valid back to ready.
   assign dig_ready = (state != FULL) & ~clear;

   always_comb begin
      accept  = dig_valid & dig_ready;
      legal   = (dig <= 4'd9);
      take    = accept & legal;
      // Post-accept view of the working register; a commit in the same
      // cycle publishes this, so a digit offered alongside ENTER is kept.
      work_nx = take ? ((work << 4) | W'(dig)) : work;
      cnt_nx  = take ? (cnt + CW'(1)) : cnt;
      full_nx = (cnt_nx == CW'(NDIGITS));
`ifdef AUTO_COMMIT_EN
      commit  = (enter & (cnt_nx != '0)) | (take & full_nx);
`else
      commit  = enter & (cnt_nx != '0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         work      <= '0;
         cnt       <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         if (clear) begin
            // bcd is deliberately left alone: it is the last committed word.
            state <= EMPTY;
            work  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
         end else begin
            // Illegal digits are consumed but never reach the working
            // register, so every published nibble stays in 0..9.
            if (accept && !legal)
               err <= 1'b1;
            if (commit) begin
               bcd       <= work_nx;
               bcd_valid <= 1'b1;
               work      <= '0;
               cnt       <= '0;
               state     <= EMPTY;
            end else begin
               work <= work_nx;
               cnt  <= cnt_nx;
               if (cnt_nx == '0)
                  state <= EMPTY;
               else if (full_nx)
                  state <= FULL;
               else
                  state <= PARTIAL;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_digit_entry.sv
// ============================================================================
//  Module      : tb_bcd_digit_entry
//  Description : Self-checking bench for bcd_digit_entry (NDIGITS=2) using a
//                table of directed vectors plus a hand-written reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_digit_entry;

   logic       clk;
   logic       rst_n;
   logic       dig_valid;
   logic [3:0] dig;
   logic       dig_ready;
   logic       enter;
   logic       clear;
   logic [7:0] bcd;
   logic       bcd_valid;
   logic       err;
   logic [1:0] cnt;

   int total;
   int bad;

   bcd_digit_entry #(.NDIGITS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dig_valid (dig_valid),
      .dig       (dig),
      .dig_ready (dig_ready),
      .enter     (enter),
      .clear     (clear),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .err       (err),
      .cnt       (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus: inputs, ready expected before the edge, and
   // registered outputs expected after the edge.
   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       en;
      logic       clr;
      logic       rdy;
      logic [7:0] bcd;
      logic       bv;
      logic       err;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [3:0] d, input logic en,
                      input logic clr, input logic rdy, input logic [7:0] b,
                      input logic bv, input logic e, input logic [1:0] c);
      vec_t t;
      t.v = v; t.d = d; t.en = en; t.clr = clr; t.rdy = rdy;
      t.bcd = b; t.bv = bv; t.err = e; t.cnt = c;
      vecs.push_back(t);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      dig_valid = 1'b0;
      dig = 4'd0;
      enter = 1'b0;
      clear = 1'b0;

      //    v  dig   en clr  rdy bcd    bv err cnt
`ifdef AUTO_COMMIT_EN
      add(1, 4'd1, 0, 0,   1, 8'h00, 0, 0, 2'd1);
      add(1, 4'd8, 0, 0,   1, 8'h18, 1, 0, 2'd0); // fill commits itself
      add(0, 4'd0, 0, 0,   1, 8'h18, 0, 0, 2'd0); // strobe lasts one cycle
      add(1, 4'd3, 1, 0,   1, 8'h03, 1, 0, 2'd0); // ENTER still commits partial
      add(1, 4'd9, 0, 0,   1, 8'h03, 0, 0, 2'd1);
      add(1, 4'd9, 0, 0,   1, 8'h99, 1, 0, 2'd0);
`else
      add(1, 4'd6, 0, 0,   1, 8'h00, 0, 0, 2'd1);
      add(1, 4'd3, 0, 0,   1, 8'h00, 0, 0, 2'd2);
      add(0, 4'd0, 1, 0,   0, 8'h63, 1, 0, 2'd0); // commit from FULL
      add(0, 4'd0, 0, 0,   1, 8'h63, 0, 0, 2'd0); // strobe lasts one cycle
      add(1, 4'd7, 0, 0,   1, 8'h63, 0, 0, 2'd1);
      add(0, 4'd0, 1, 0,   1, 8'h07, 1, 0, 2'd0);
      add(0, 4'd0, 1, 0,   1, 8'h07, 0, 0, 2'd0); // ENTER while empty ignored
      add(1, 4'd9, 0, 0,   1, 8'h07, 0, 0, 2'd1);
      add(1, 4'd9, 0, 0,   1, 8'h07, 0, 0, 2'd2);
      add(1, 4'd5, 0, 0,   0, 8'h07, 0, 0, 2'd2); // FULL stalls source
      add(1, 4'd5, 0, 0,   0, 8'h07, 0, 0, 2'd2);
      add(0, 4'd0, 1, 0,   0, 8'h99, 1, 0, 2'd0);
      add(1, 4'd4, 0, 0,   1, 8'h99, 0, 0, 2'd1);
      add(1, 4'hC, 0, 0,   1, 8'h99, 0, 1, 2'd1); // illegal: consumed, err set
      add(1, 4'd2, 1, 0,   1, 8'h42, 1, 1, 2'd0); // digit joins same-cycle commit
      add(0, 4'd0, 0, 1,   0, 8'h42, 0, 0, 2'd0); // clear drops err, ready low
      add(1, 4'd5, 0, 0,   1, 8'h42, 0, 0, 2'd1);
      add(1, 4'd8, 1, 1,   0, 8'h42, 0, 0, 2'd0); // clear beats enter and accept
      add(1, 4'd1, 1, 0,   1, 8'h01, 1, 0, 2'd0); // enter held high
      add(0, 4'd0, 1, 0,   1, 8'h01, 0, 0, 2'd0); // held, empty: no strobe
      add(1, 4'd2, 1, 0,   1, 8'h02, 1, 0, 2'd0);
      add(1, 4'd9, 0, 0,   1, 8'h02, 0, 0, 2'd1);
      add(1, 4'hC, 0, 0,   1, 8'h02, 0, 1, 2'd1);
      add(1, 4'd1, 0, 0,   1, 8'h02, 0, 1, 2'd2);
      add(1, 4'hD, 0, 0,   0, 8'h02, 0, 1, 2'd2); // not accepted while FULL
      add(0, 4'd0, 1, 0,   0, 8'h91, 1, 1, 2'd0); // err does not block commit
`endif

      // Reset state
      #12;
      check("reset bcd", bcd, 8'h00);
      check("reset bcd_valid", bcd_valid, 0);
      check("reset err", err, 0);
      check("reset cnt", cnt, 0);
      check("reset dig_ready", dig_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         dig_valid = vecs[i].v;
         dig       = vecs[i].d;
         enter     = vecs[i].en;
         clear     = vecs[i].clr;
         #1;
         check($sformatf("v%0d dig_ready", i), dig_ready, vecs[i].rdy);
         @(posedge clk);
         #1;
         check($sformatf("v%0d bcd", i), bcd, vecs[i].bcd);
         check($sformatf("v%0d bcd_valid", i), bcd_valid, vecs[i].bv);
         check($sformatf("v%0d err", i), err, vecs[i].err);
         check($sformatf("v%0d cnt", i), cnt, vecs[i].cnt);
      end

      // Asynchronous reset mid-entry: no clock edge between assert and check.
      dig_valid = 1'b1;
      dig       = 4'd5;
      enter     = 1'b0;
      clear     = 1'b0;
      @(posedge clk);
      #1;
      dig_valid = 1'b0;
      check("mid cnt", cnt, 1);
      dig_valid = 1'b1;
      dig       = 4'hE;
      @(posedge clk);
      #1;
      dig_valid = 1'b0;
      check("mid err", err, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async bcd", bcd, 8'h00);
      check("async bcd_valid", bcd_valid, 0);
      check("async err", err, 0);
      check("async cnt", cnt, 0);
      check("async dig_ready", dig_ready, 1);
      #10;
      rst_n = 1'b1;
      // Old partial digit must be gone: ENTER alone gives no strobe.
      @(posedge clk);
      #1;
      enter = 1'b1;
      @(posedge clk);
      #1;
      enter = 1'b0;
      check("post-reset enter bcd_valid", bcd_valid, 0);
      check("post-reset enter bcd", bcd, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
